// File: rtl/sync_fifo_flags_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_flags_if
// Description : Bundles the write, read, status and error-control signals of
//               the single-clock flagged FIFO.
//               master modport : the user side of the FIFO. It drives the
//                                requests and observes data and status.
//               slave modport  : the FIFO itself.
//               Signals
//                 winc, wdata          write request and write data
//                 rinc                 read request / pop
//                 rdata, rvalid        read data and its valid qualifier
//                 wfull, rempty        occupancy extremes
//                 walmost_full         count >= almost-full threshold
//                 ralmost_empty        count <= almost-empty threshold
//                 count                occupancy, 0..2^ADDRSIZE
//                 overflow, underflow  sticky error flags
//                 clr_err              clears the sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_flags_if #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 4
);
   logic                winc;
   logic [DATASIZE-1:0] wdata;
   logic                rinc;
   logic [DATASIZE-1:0] rdata;
   logic                rvalid;
   logic                wfull;
   logic                rempty;
   logic                walmost_full;
   logic                ralmost_empty;
   logic [ADDRSIZE:0]   count;
   logic                overflow;
   logic                underflow;
   logic                clr_err;

   modport master (
      output winc, wdata, rinc, clr_err,
      input  rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  winc, wdata, rinc, clr_err,
      output rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty,
             count, overflow, underflow
   );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_flags
// Description : Single-clock FIFO of 2^ADDRSIZE words of DATASIZE bits. It
//               provides a fill-level count, programmable almost-full and
//               almost-empty flags, sticky overflow and underflow flags, and
//               a choice of registered read or first-word-fall-through.
//               Ports
//                 clk  : clock. All state changes on its rising edge.
//                 rst  : asynchronous active-high reset. It clears the
//                        pointers, error flags and read outputs.
//                 bus  : sync_fifo_flags_if.slave
//                        (winc/wdata, rinc/rdata/rvalid, wfull, rempty,
//                         walmost_full, ralmost_empty, count, overflow,
//                         underflow, clr_err)
//               Parameters
//                 DATASIZE   : word width
//                 ADDRSIZE   : address width. The depth is 2^ADDRSIZE.
//                 FWFT       : 0 = registered read, 1 = fall-through
//                 AFULL_LVL  : walmost_full when count >= AFULL_LVL (1..DEPTH)
//                 AEMPTY_LVL : ralmost_empty when count <= AEMPTY_LVL
//                              (0..DEPTH-1)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_flags #(
   parameter int DATASIZE   = 8,
   parameter int ADDRSIZE   = 4,
   parameter int FWFT       = 0,
   parameter int AFULL_LVL  = 14,
   parameter int AEMPTY_LVL = 2
) (
   input  wire logic         clk,
   input  wire logic         rst,
   sync_fifo_flags_if.slave  bus
);

   localparam int                c_depth      = 1 << ADDRSIZE;
   localparam logic [ADDRSIZE:0] c_afull_lvl  = (ADDRSIZE+1)'(AFULL_LVL);
   localparam logic [ADDRSIZE:0] c_aempty_lvl = (ADDRSIZE+1)'(AEMPTY_LVL);
   localparam logic [ADDRSIZE:0] c_ptr_one    = (ADDRSIZE+1)'(1);

   // ------------------------------------------------------------------------
   // Storage and pointers
   // ------------------------------------------------------------------------
   // The memory array is deliberately left out of reset. The pointers alone
   // define what is valid, so discarding contents only needs the pointers.
   logic [DATASIZE-1:0] r_mem [c_depth];

   // The pointers carry one extra bit beyond the address. That bit tells a
   // full FIFO (same address, different wrap parity) from an empty one
   // (identical pointers).
   logic [ADDRSIZE:0]   r_wptr;
   logic [ADDRSIZE:0]   r_rptr;

   logic                r_overflow;
   logic                r_underflow;

   logic [ADDRSIZE-1:0] w_waddr;
   logic [ADDRSIZE-1:0] w_raddr;
   logic [ADDRSIZE:0]   w_count;
   logic                w_empty;
   logic                w_full;
   logic                w_wr_en;
   logic                w_rd_en;
   logic                w_wr_err;
   logic                w_rd_err;

   assign w_waddr = r_wptr[ADDRSIZE-1:0];
   assign w_raddr = r_rptr[ADDRSIZE-1:0];

   // ------------------------------------------------------------------------
   // Status. All of it is decoded from the registered pointers, so an
   // accepted operation shows up in the cycle after its clock edge.
   // ------------------------------------------------------------------------
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[ADDRSIZE] != r_rptr[ADDRSIZE]) &&
                    (w_waddr == w_raddr);

   // Modular subtraction gives the occupancy directly, including across the
   // natural wrap of either pointer.
   assign w_count = r_wptr - r_rptr;

   // Requests are qualified against the flags as they stood before the edge.
   // A simultaneous read and write on a full FIFO therefore still rejects
   // the write, and on an empty FIFO it still rejects the read.
   assign w_wr_en  = bus.winc && !w_full;
   assign w_rd_en  = bus.rinc && !w_empty;
   assign w_wr_err = bus.winc &&  w_full;
   assign w_rd_err = bus.rinc &&  w_empty;

   assign bus.count         = w_count;
   assign bus.rempty        = w_empty;
   assign bus.wfull         = w_full;
   assign bus.walmost_full  = (w_count >= c_afull_lvl);
   assign bus.ralmost_empty = (w_count <= c_aempty_lvl);
   assign bus.overflow      = r_overflow;
   assign bus.underflow     = r_underflow;

   // ------------------------------------------------------------------------
   // Memory write port
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_waddr] <= bus.wdata;
      end
   end

   // ------------------------------------------------------------------------
   // Pointer update
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr_en) begin
            r_wptr <= r_wptr + c_ptr_one;
         end
         if (w_rd_en) begin
            r_rptr <= r_rptr + c_ptr_one;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Sticky error flags. If a new error arrives in the same cycle as clr_err,
   // the set takes priority, so that the error is not lost.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_err) begin
            r_overflow <= 1'b1;
         end else if (bus.clr_err) begin
            r_overflow <= 1'b0;
         end

         if (w_rd_err) begin
            r_underflow <= 1'b1;
         end else if (bus.clr_err) begin
            r_underflow <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Read port
   // ------------------------------------------------------------------------
   generate
      if (FWFT != 0) begin : g_fwft
         // The head word is always presented. The output is forced to zero
         // while empty, so that it never shows uninitialised memory and it
         // reads as zero during reset.
         assign bus.rdata  = w_empty ? '0 : r_mem[w_raddr];
         assign bus.rvalid = !w_empty;
      end else begin : g_reg_read
         logic [DATASIZE-1:0] r_rdata;
         logic                r_rvalid;

         // rvalid is a one-cycle strobe per accepted read. rdata holds its
         // last value between reads.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_rdata  <= '0;
               r_rvalid <= 1'b0;
            end else begin
               r_rvalid <= w_rd_en;
               if (w_rd_en) begin
                  r_rdata <= r_mem[w_raddr];
               end
            end
         end

         assign bus.rdata  = r_rdata;
         assign bus.rvalid = r_rvalid;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_flags
// Description : Self-checking bench for sync_fifo_flags. u_dut0 uses a
//               registered read (FWFT=0) and u_dut1 uses fall-through
//               (FWFT=1). A queue scoreboard holds the words accepted by
//               u_dut0 in the order they must come back out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_flags;

   localparam int c_depth = 16;

   logic clk;
   logic rst;

   sync_fifo_flags_if #(.DATASIZE(8), .ADDRSIZE(4)) bus0 ();
   sync_fifo_flags_if #(.DATASIZE(8), .ADDRSIZE(4)) bus1 ();

   sync_fifo_flags #(
      .DATASIZE(8), .ADDRSIZE(4), .FWFT(0), .AFULL_LVL(14), .AEMPTY_LVL(2)
   ) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   sync_fifo_flags #(
      .DATASIZE(8), .ADDRSIZE(4), .FWFT(1), .AFULL_LVL(14), .AEMPTY_LVL(2)
   ) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;

   // Reference model for u_dut0
   logic [7:0] sb [$];
   int         m_count;
   logic       m_ovf;
   logic       m_udf;
   logic       exp_valid;
   logic [7:0] exp_data;

   task automatic model_reset();
      sb.delete();
      m_count   = 0;
      m_ovf     = 1'b0;
      m_udf     = 1'b0;
      exp_valid = 1'b0;
      exp_data  = 8'h00;
   endtask

   // This task drives one clock cycle on u_dut0 and advances the model. The
   // expected read word is popped at the edge where the read is accepted,
   // which is the same edge at which the registered rdata updates.
   task automatic step0(input logic w, input logic [7:0] d,
                        input logic r, input logic c);
      logic wacc;
      logic racc;
      bus0.winc    = w;
      bus0.wdata   = d;
      bus0.rinc    = r;
      bus0.clr_err = c;
      @(posedge clk);
      #1;
      wacc = w && (m_count != c_depth);
      racc = r && (m_count != 0);
      if (w && !wacc)   m_ovf = 1'b1;
      else if (c)       m_ovf = 1'b0;
      if (r && !racc)   m_udf = 1'b1;
      else if (c)       m_udf = 1'b0;
      exp_valid = racc;
      if (racc) exp_data = sb.pop_front();
      if (wacc) sb.push_back(d);
      m_count = m_count + int'(wacc) - int'(racc);
      bus0.winc    = 1'b0;
      bus0.rinc    = 1'b0;
      bus0.clr_err = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      step0(1'b0, 8'h00, 1'b1, 1'b0);   // underflow on empty
      step0(1'b1, 8'hC1, 1'b0, 1'b0);
      step0(1'b1, 8'hC2, 1'b0, 1'b0);
      step0(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (bus0.rvalid !== 1'b1 || bus0.rdata !== 8'hC1) begin
         n_fail++;
         $display("FAIL pre_reset_read: got rvalid=%b rdata=%h, expected 1/c1",
                  bus0.rvalid, bus0.rdata);
      end
      n_checks++;
      if (bus0.underflow !== 1'b1 || bus0.count !== 5'd1) begin
         n_fail++;
         $display("FAIL pre_reset_state: got underflow=%b count=%0d, expected 1/1",
                  bus0.underflow, bus0.count);
      end
      // Assert reset in the middle of a cycle, with a write pending. Nothing
      // may wait for a clock edge before it clears.
      bus0.winc  = 1'b1;
      bus0.wdata = 8'hC3;
      rst = 1'b1;
      #2;
      n_checks++;
      if (bus0.count !== 5'd0 || bus0.rempty !== 1'b1 ||
          bus0.ralmost_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_empty: got count=%0d rempty=%b raempty=%b, expected 0/1/1",
                  bus0.count, bus0.rempty, bus0.ralmost_empty);
      end
      n_checks++;
      if (bus0.wfull !== 1'b0 || bus0.walmost_full !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_full: got wfull=%b wafull=%b, expected 0/0",
                  bus0.wfull, bus0.walmost_full);
      end
      n_checks++;
      if (bus0.overflow !== 1'b0 || bus0.underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_err: got ovf=%b udf=%b, expected 0/0",
                  bus0.overflow, bus0.underflow);
      end
      n_checks++;
      if (bus0.rvalid !== 1'b0 || bus0.rdata !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_rd: got rvalid=%b rdata=%h, expected 0/00",
                  bus0.rvalid, bus0.rdata);
      end
      n_checks++;
      if (bus1.rvalid !== 1'b0 || bus1.rempty !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_fwft: got rvalid=%b rempty=%b, expected 0/1",
                  bus1.rvalid, bus1.rempty);
      end
      bus0.winc = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_fill();
      for (int i = 0; i < c_depth; i++) begin
         step0(1'b1, 8'(i), 1'b0, 1'b0);
         n_checks++;
         if (bus0.count !== 5'(i + 1) || bus0.rempty !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_count[%0d]: got count=%0d rempty=%b, expected %0d/0",
                     i, bus0.count, bus0.rempty, i + 1);
         end
         n_checks++;
         if (bus0.walmost_full !== ((i + 1) >= 14) ||
             bus0.wfull !== ((i + 1) == c_depth)) begin
            n_fail++;
            $display("FAIL fill_flags[%0d]: got wafull=%b wfull=%b, expected %b/%b",
                     i, bus0.walmost_full, bus0.wfull, (i + 1) >= 14,
                     (i + 1) == c_depth);
         end
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_overflow_drain();
      step0(1'b1, 8'hAA, 1'b0, 1'b0);
      n_checks++;
      if (bus0.overflow !== 1'b1 || bus0.count !== 5'd16 || bus0.wfull !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow: got ovf=%b count=%0d wfull=%b, expected 1/16/1",
                  bus0.overflow, bus0.count, bus0.wfull);
      end
      for (int i = 0; i < c_depth; i++) begin
         step0(1'b0, 8'h00, 1'b1, 1'b0);
         n_checks++;
         if (bus0.rvalid !== 1'b1 || bus0.rdata !== exp_data ||
             bus0.rdata !== 8'(i)) begin
            n_fail++;
            $display("FAIL drain_data[%0d]: got rvalid=%b rdata=%h, expected 1/%h",
                     i, bus0.rvalid, bus0.rdata, exp_data);
         end
         n_checks++;
         if (bus0.count !== 5'(15 - i) ||
             bus0.ralmost_empty !== ((15 - i) <= 2) ||
             bus0.rempty !== (i == 15) || bus0.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_flags[%0d]: got count=%0d raempty=%b rempty=%b ovf=%b",
                     i, bus0.count, bus0.ralmost_empty, bus0.rempty, bus0.overflow);
         end
      end
      step0(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (bus0.underflow !== 1'b1 || bus0.count !== 5'd0 ||
          bus0.rvalid !== 1'b0 || bus0.rempty !== 1'b1) begin
         n_fail++;
         $display("FAIL underflow: got udf=%b count=%0d rvalid=%b rempty=%b, expected 1/0/0/1",
                  bus0.underflow, bus0.count, bus0.rvalid, bus0.rempty);
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_latency();
      step0(1'b0, 8'h00, 1'b0, 1'b1);
      n_checks++;
      if (bus0.overflow !== 1'b0 || bus0.underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_both: got ovf=%b udf=%b, expected 0/0",
                  bus0.overflow, bus0.underflow);
      end
      step0(1'b1, 8'h5A, 1'b0, 1'b0);
      n_checks++;
      if (bus0.rvalid !== 1'b0 || bus0.count !== 5'd1) begin
         n_fail++;
         $display("FAIL lat_write: got rvalid=%b count=%0d, expected 0/1",
                  bus0.rvalid, bus0.count);
      end
      step0(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (bus0.rvalid !== 1'b1 || bus0.rdata !== 8'h5A || exp_data !== 8'h5A) begin
         n_fail++;
         $display("FAIL lat_read: got rvalid=%b rdata=%h, expected 1/5a",
                  bus0.rvalid, bus0.rdata);
      end
      step0(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++;
      if (bus0.rvalid !== 1'b0 || bus0.rdata !== 8'h5A) begin
         n_fail++;
         $display("FAIL lat_hold: got rvalid=%b rdata=%h, expected 0/5a",
                  bus0.rvalid, bus0.rdata);
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_fwft();
      bus1.winc  = 1'b1;
      bus1.wdata = 8'h11;
      @(posedge clk);
      #1;
      bus1.wdata = 8'h22;
      n_checks++;
      if (bus1.rvalid !== 1'b1 || bus1.rdata !== 8'h11) begin
         n_fail++;
         $display("FAIL fwft_first: got rvalid=%b rdata=%h, expected 1/11",
                  bus1.rvalid, bus1.rdata);
      end
      @(posedge clk);
      #1;
      bus1.winc = 1'b0;
      n_checks++;
      if (bus1.rdata !== 8'h11 || bus1.count !== 5'd2) begin
         n_fail++;
         $display("FAIL fwft_hold: got rdata=%h count=%0d, expected 11/2",
                  bus1.rdata, bus1.count);
      end
      bus1.rinc = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus1.rvalid !== 1'b1 || bus1.rdata !== 8'h22) begin
         n_fail++;
         $display("FAIL fwft_pop: got rvalid=%b rdata=%h, expected 1/22",
                  bus1.rvalid, bus1.rdata);
      end
      @(posedge clk);
      #1;
      bus1.rinc = 1'b0;
      n_checks++;
      if (bus1.rvalid !== 1'b0 || bus1.rempty !== 1'b1) begin
         n_fail++;
         $display("FAIL fwft_empty: got rvalid=%b rempty=%b, expected 0/1",
                  bus1.rvalid, bus1.rempty);
      end
   endtask

   // ------------------------------------------------------------------------
   // Hold eight words in flight while reading and writing together. The
   // pointers wrap during the 40 cycles. Word k written is 0x80+k, so the
   // k-th word read must also be 0x80+k.
   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) step0(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         step0(1'b1, 8'(8'h88 + i), 1'b1, 1'b0);
         n_checks++;
         if (bus0.count !== 5'd8 || bus0.rvalid !== 1'b1 ||
             bus0.rdata !== exp_data || bus0.rdata !== 8'(8'h80 + i)) begin
            n_fail++;
            $display("FAIL b2b[%0d]: got count=%0d rvalid=%b rdata=%h, expected 8/1/%h",
                     i, bus0.count, bus0.rvalid, bus0.rdata, exp_data);
         end
      end
      for (int i = 0; i < 8; i++) begin
         step0(1'b0, 8'h00, 1'b1, 1'b0);
         n_checks++;
         if (bus0.rdata !== exp_data || bus0.rdata !== 8'(8'hA8 + i)) begin
            n_fail++;
            $display("FAIL b2b_drain[%0d]: got rdata=%h, expected %h",
                     i, bus0.rdata, exp_data);
         end
      end
      n_checks++;
      if (bus0.rempty !== 1'b1 || bus0.underflow !== m_udf) begin
         n_fail++;
         $display("FAIL b2b_end: got rempty=%b udf=%b, expected 1/%b",
                  bus0.rempty, bus0.underflow, m_udf);
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_clr_err();
      for (int i = 0; i < c_depth; i++) step0(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
      step0(1'b1, 8'hEE, 1'b0, 1'b1);
      n_checks++;
      if (bus0.overflow !== 1'b1 || bus0.count !== 5'd16 || m_ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_vs_set: got ovf=%b count=%0d, expected 1/16",
                  bus0.overflow, bus0.count);
      end
      step0(1'b0, 8'h00, 1'b0, 1'b1);
      n_checks++;
      if (bus0.overflow !== 1'b0 || bus0.count !== 5'd16) begin
         n_fail++;
         $display("FAIL clr_alone: got ovf=%b count=%0d, expected 0/16",
                  bus0.overflow, bus0.count);
      end
   endtask

   // ------------------------------------------------------------------------
   initial begin
      rst          = 1'b1;
      bus0.winc    = 1'b0;
      bus0.wdata   = 8'h00;
      bus0.rinc    = 1'b0;
      bus0.clr_err = 1'b0;
      bus1.winc    = 1'b0;
      bus1.wdata   = 8'h00;
      bus1.rinc    = 1'b0;
      bus1.clr_err = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      test_reset();
      test_fill();
      test_overflow_drain();
      test_latency();
      test_fwft();
      test_back_to_back();
      test_clr_err();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
